// File: rtl/judge_hp.sv
// Round judge and HP tracker for the game controller: resolves each answer round and ends the game at HP 0.
// Optional WRONG_PENALTY_EN: a local wrong answer also costs the local player DMG HP.
module judge_hp #(
    parameter int HP_INIT  = 3,
    parameter int HP_W     = 3,
    parameter int DMG      = 1,
    parameter int DRAW_WIN = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [3:0]      STATE,
    input  logic            ANS_DEC,
    input  logic            ANS_OK,
    input  logic            OPP_VALID,
    output logic [1:0]      JUDG_OUT,
    output logic            WRONG_OUT,
    output logic [1:0]      HP_OUT,
    output logic [HP_W-1:0] HP_SELF,
    output logic [HP_W-1:0] HP_OPP
);

    localparam logic [3:0] ST_READY = 4'b0010;
    localparam logic [3:0] ST_INPUT = 4'b0100;
    localparam logic [3:0] ST_WRONG = 4'b0111;

    localparam int              CNT_W     = $clog2(DRAW_WIN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DRAW_WIN - 1);
    localparam logic [HP_W-1:0]  HP_RELOAD = HP_W'(HP_INIT);

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_ARMED,
        FSM_WAIT_L,
        FSM_WAIT_O,
        FSM_RESULT,
        FSM_WRONGH
    } fsm_t;

    fsm_t             fsm, fsm_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       judg_nxt;
    logic             wrong_nxt;
    logic [1:0]       hp_out_nxt;
    logic [HP_W-1:0]  hp_self_nxt, hp_opp_nxt;
    logic [HP_W-1:0]  self_dec, opp_dec;
    logic             in_input, ans_good;

    // Damage never wraps below zero.
    function automatic logic [HP_W-1:0] sat_dmg(input logic [HP_W-1:0] hp);
        if (int'(hp) > DMG)
            return hp - HP_W'(DMG);
        else
            return '0;
    endfunction

    assign in_input = (STATE == ST_INPUT);
    assign ans_good = ANS_DEC & ANS_OK;
    assign self_dec = sat_dmg(HP_SELF);
    assign opp_dec  = sat_dmg(HP_OPP);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fsm       <= FSM_IDLE;
            cnt       <= '0;
            JUDG_OUT  <= 2'b00;
            WRONG_OUT <= 1'b0;
            HP_OUT    <= 2'b00;
            HP_SELF   <= HP_RELOAD;
            HP_OPP    <= HP_RELOAD;
        end else begin
            fsm       <= fsm_nxt;
            cnt       <= cnt_nxt;
            JUDG_OUT  <= judg_nxt;
            WRONG_OUT <= wrong_nxt;
            HP_OUT    <= hp_out_nxt;
            HP_SELF   <= hp_self_nxt;
            HP_OPP    <= hp_opp_nxt;
        end
    end

    always_comb begin
        fsm_nxt     = fsm;
        cnt_nxt     = cnt;
        judg_nxt    = JUDG_OUT;
        wrong_nxt   = WRONG_OUT;
        hp_out_nxt  = HP_OUT;
        hp_self_nxt = HP_SELF;
        hp_opp_nxt  = HP_OPP;

        // A finished game is wiped when the controller returns to READY.
        if (STATE == ST_READY && HP_OUT != 2'b00) begin
            hp_out_nxt  = 2'b00;
            hp_self_nxt = HP_RELOAD;
            hp_opp_nxt  = HP_RELOAD;
        end

        case (fsm)
            FSM_IDLE: begin
                if (in_input)
                    fsm_nxt = FSM_ARMED;
            end
            FSM_ARMED: begin
                if (!in_input) begin
                    fsm_nxt = FSM_IDLE;
                end else if (ans_good && OPP_VALID) begin
                    fsm_nxt  = FSM_RESULT;
                    judg_nxt = 2'b11;
                end else if (ans_good) begin
                    fsm_nxt = FSM_WAIT_L;
                    cnt_nxt = '0;
                end else if (OPP_VALID) begin
                    fsm_nxt = FSM_WAIT_O;
                    cnt_nxt = '0;
                end else if (ANS_DEC) begin
                    fsm_nxt   = FSM_WRONGH;
                    wrong_nxt = 1'b1;
`ifdef WRONG_PENALTY_EN
                    hp_self_nxt = self_dec;
                    if (self_dec == '0 && HP_OUT == 2'b00)
                        hp_out_nxt = 2'b10;
`endif
                end
            end
            FSM_WAIT_L: begin
                if (!in_input) begin
                    fsm_nxt = FSM_IDLE;
                end else if (OPP_VALID) begin
                    fsm_nxt  = FSM_RESULT;
                    judg_nxt = 2'b11;
                end else if (cnt == CNT_LAST) begin
                    fsm_nxt    = FSM_RESULT;
                    judg_nxt   = 2'b01;
                    hp_opp_nxt = opp_dec;
                    if (opp_dec == '0 && HP_OUT == 2'b00)
                        hp_out_nxt = 2'b01;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FSM_WAIT_O: begin
                if (!in_input) begin
                    fsm_nxt = FSM_IDLE;
                end else if (ans_good) begin
                    fsm_nxt  = FSM_RESULT;
                    judg_nxt = 2'b11;
                end else if (cnt == CNT_LAST) begin
                    fsm_nxt     = FSM_RESULT;
                    judg_nxt    = 2'b10;
                    hp_self_nxt = self_dec;
                    if (self_dec == '0 && HP_OUT == 2'b00)
                        hp_out_nxt = 2'b10;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FSM_RESULT: begin
                if (!in_input) begin
                    fsm_nxt  = FSM_IDLE;
                    judg_nxt = 2'b00;
                end
            end
            FSM_WRONGH: begin
                if (STATE == ST_WRONG) begin
                    fsm_nxt   = FSM_IDLE;
                    wrong_nxt = 1'b0;
                end
            end
            default: fsm_nxt = FSM_IDLE;
        endcase
    end

endmodule
